// File: rtl/lsu_unit_pkg.sv
// rtl/lsu_unit_pkg.sv - shared op/state types and decode helpers for lsu_unit
// Imported by lsu_align and lsu_unit.
package lsu_unit_pkg;

  typedef enum logic [2:0] {
    OP_B   = 3'b000,
    OP_H   = 3'b001,
    OP_W   = 3'b010,
    OP_D   = 3'b011,
    OP_BU  = 3'b100,
    OP_HU  = 3'b101,
    OP_WU  = 3'b110,
    OP_BAD = 3'b111
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } lsu_state_e;

  function automatic logic [3:0] op_size(input logic [2:0] op);
    return 4'd1 << op[1:0];
  endfunction

  // op[2] marks the unsigned load variants, which have no store counterpart
  function automatic logic op_illegal(input logic we, input logic [2:0] op, input int data_w);
    logic bad;
    bad = (op == OP_BAD) || (we && op[2]);
    if (data_w == 32) bad = bad || (op == OP_D) || (op == OP_WU);
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shift/mask and load merge/extension
// Purely combinational; i_beat selects which half of the shifted store window drives the bus.
module lsu_align
  import lsu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int B = DATA_W / 8,
  localparam int OFF_W = $clog2(B)
) (
  input  logic [2:0]        i_op,
  input  logic [OFF_W-1:0]  i_off,
  input  logic              i_beat,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_beat0,
  input  logic [DATA_W-1:0] i_beat1,
  output logic [DATA_W-1:0] o_wdata,
  output logic [B-1:0]      o_wmask,
  output logic [DATA_W-1:0] o_rdata
);

  logic [3:0]          w_size;
  logic [OFF_W+2:0]    w_bitoff;
  logic [DATA_W-1:0]   w_wtrim;
  logic [B-1:0]        w_smask;
  logic [2*DATA_W-1:0] w_wwide;
  logic [2*B-1:0]      w_mwide;
  logic [DATA_W-1:0]   w_raw;
  logic                w_top;
  logic                w_sbit;

  assign w_size   = op_size(i_op);
  assign w_bitoff = {i_off, 3'b000};

  always_comb begin
    w_wtrim = '0;
    w_smask = '0;
    for (int i = 0; i < DATA_W; i++) w_wtrim[i] = (i < 8 * int'(w_size)) ? i_wdata[i] : 1'b0;
    for (int i = 0; i < B; i++) w_smask[i] = (i < int'(w_size));
  end

  // A 2-word window so bytes pushed past lane B-1 land in the second beat
  assign w_wwide = {{DATA_W{1'b0}}, w_wtrim} << w_bitoff;
  assign w_mwide = {{B{1'b0}}, w_smask} << i_off;
  assign o_wdata = i_beat ? w_wwide[2*DATA_W-1:DATA_W] : w_wwide[DATA_W-1:0];
  assign o_wmask = i_beat ? w_mwide[2*B-1:B] : w_mwide[B-1:0];

  assign w_raw = DATA_W'({i_beat1, i_beat0} >> w_bitoff);

  always_comb begin
    case (i_op[1:0])
      2'b00:   w_top = w_raw[7];
      2'b01:   w_top = w_raw[15];
      2'b10:   w_top = w_raw[31];
      default: w_top = w_raw[DATA_W-1];
    endcase
    w_sbit  = w_top & ~i_op[2];
    o_rdata = '0;
    for (int i = 0; i < DATA_W; i++) o_rdata[i] = (i < 8 * int'(w_size)) ? w_raw[i] : w_sbit;
  end

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - load/store unit FSM between execute stage and data bus
// LSU_MISALIGN_SPLIT_EN: split word-crossing misaligned accesses into two beats; otherwise misaligned accesses fault.
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_fault,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);

  lsu_state_e        r_state, w_next;
  logic              r_we;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_beat0;
  logic              r_fault;

  logic              w_accept;
  logic [3:0]        w_req_size;
  logic [OFF_W-1:0]  w_req_off;
  logic              w_mis;
  logic              w_fault;
  logic [ADDR_W-1:0] w_base;
  logic              w_beat;
  logic [DATA_W-1:0] w_beat1;
  logic [DATA_W-1:0] w_wdata;
  logic [B-1:0]      w_wmask;
  logic [DATA_W-1:0] w_rdata;

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign w_req_size = op_size(req_op);
  assign w_req_off  = req_addr[OFF_W-1:0];
  assign w_mis      = (int'(w_req_off) & (int'(w_req_size) - 1)) != 0;
  assign w_base     = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              r_split;
  logic [DATA_W-1:0] r_beat1;
  logic              w_split;
  logic [ADDR_W-1:0] w_base1;

  assign w_split = w_mis && (int'(w_req_off) + int'(w_req_size) > B);
  assign w_fault = op_illegal(req_we, req_op, DATA_W);
  assign w_base1 = w_base + ADDR_W'(B);
  assign w_beat  = (r_state == ST_REQ1) || (r_state == ST_WAIT1);
  assign w_beat1 = r_beat1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_split <= 1'b0;
      r_beat1 <= '0;
    end else if (w_accept) begin
      r_split <= w_split;
      r_beat1 <= '0;
    end else if (r_state == ST_WAIT1 && mem_resp_valid) begin
      r_beat1 <= mem_rdata;
    end
  end
`else
  assign w_fault = op_illegal(req_we, req_op, DATA_W) || w_mis;
  assign w_beat  = 1'b0;
  assign w_beat1 = '0;
`endif

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_op    (r_op),
    .i_off   (r_addr[OFF_W-1:0]),
    .i_beat  (w_beat),
    .i_wdata (r_wdata),
    .i_beat0 (r_beat0),
    .i_beat1 (w_beat1),
    .o_wdata (w_wdata),
    .o_wmask (w_wmask),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_op    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_beat0 <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_op    <= req_op;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_beat0 <= '0;
      r_fault <= w_fault;
    end else if (r_state == ST_WAIT0 && mem_resp_valid) begin
      r_beat0 <= mem_rdata;
    end
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    resp_valid    = 1'b0;
    resp_fault    = 1'b0;
    resp_rdata    = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_fault ? ST_RESP : ST_REQ0;
      end
      ST_REQ0, ST_WAIT0: begin
        mem_req_valid = (r_state == ST_REQ0);
        mem_we        = r_we;
        mem_addr      = w_base;
        mem_wdata     = r_we ? w_wdata : '0;
        mem_wmask     = r_we ? w_wmask : '0;
        if (r_state == ST_REQ0 && mem_req_ready) w_next = ST_WAIT0;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (r_state == ST_WAIT0 && mem_resp_valid) w_next = r_split ? ST_REQ1 : ST_RESP;
`else
        if (r_state == ST_WAIT0 && mem_resp_valid) w_next = ST_RESP;
`endif
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_REQ1, ST_WAIT1: begin
        mem_req_valid = (r_state == ST_REQ1);
        mem_we        = r_we;
        mem_addr      = w_base1;
        mem_wdata     = r_we ? w_wdata : '0;
        mem_wmask     = r_we ? w_wmask : '0;
        if (r_state == ST_REQ1 && mem_req_ready) w_next = ST_WAIT1;
        if (r_state == ST_WAIT1 && mem_resp_valid) w_next = ST_RESP;
      end
`endif
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_fault = r_fault;
        resp_rdata = (r_fault || r_we) ? '0 : w_rdata;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_unit.sv
// tb/tb_lsu_unit.sv - directed self-checking bench for lsu_unit (DATA_W = 32)
// Expectations for misaligned cases follow LSU_MISALIGN_SPLIT_EN.
module tb_lsu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lsu_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // beats = 0 means the access must fault at cycle 1 with no bus traffic
  task automatic run_access(input string tag, input logic we, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata, input int beats,
                            input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] m0,
                            input logic [31:0] b0,
                            input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] m1,
                            input logic [31:0] b1, input logic [31:0] exp_rdata);
    check({tag, ".ready0"}, req_ready, 1);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    mem_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, ".ready1"}, req_ready, 0);
    for (int k = 0; k < beats; k++) begin
      check({tag, ".mreqv"}, mem_req_valid, 1);
      check({tag, ".maddr"}, mem_addr, (k == 0) ? a0 : a1);
      check({tag, ".mwe"}, mem_we, we);
      check({tag, ".mmask"}, mem_wmask, we ? ((k == 0) ? m0 : m1) : 4'h0);
      if (we) check({tag, ".mwdata"}, mem_wdata, (k == 0) ? d0 : d1);
      check({tag, ".early_resp"}, resp_valid, 0);
      step();
      check({tag, ".mreqv_wait"}, mem_req_valid, 0);
      mem_resp_valid = 1'b1;
      mem_rdata = (k == 0) ? b0 : b1;
      step();
      mem_resp_valid = 1'b0;
      mem_rdata = '0;
    end
    check({tag, ".resp_valid"}, resp_valid, 1);
    check({tag, ".resp_fault"}, resp_fault, (beats == 0) ? 1'b1 : 1'b0);
    check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, ".no_mreq"}, mem_req_valid, 0);
    step();
    check({tag, ".resp_drop"}, resp_valid, 0);
    check({tag, ".idle"}, req_ready, 1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b000;
    req_addr = '0; req_wdata = '0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_rdata = '0;
    step();
    step();
    check("rst.req_ready", req_ready, 1);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.resp_rdata", resp_rdata, 0);
    check("rst.resp_fault", resp_fault, 0);
    check("rst.mem_req_valid", mem_req_valid, 0);
    check("rst.mem_bus", {mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
    rst = 1'b0;
    step();

    run_access("sw", 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 1,
               32'h8000_0004, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 0, 0, 0);
    run_access("lb", 0, 3'b000, 32'h8000_0003, 0, 1,
               32'h8000_0000, 0, 0, 32'h80FF_0000, 0, 0, 0, 0, 32'hFFFF_FF80);
    run_access("lbu", 0, 3'b100, 32'h8000_0003, 0, 1,
               32'h8000_0000, 0, 0, 32'h80FF_0000, 0, 0, 0, 0, 32'h0000_0080);
    run_access("sh", 1, 3'b001, 32'h8000_0002, 32'h0000_1234, 1,
               32'h8000_0000, 32'h1234_0000, 4'b1100, 0, 0, 0, 0, 0, 0);
    run_access("sb", 1, 3'b000, 32'h8000_0001, 32'h0000_005A, 1,
               32'h8000_0000, 32'h0000_5A00, 4'b0010, 0, 0, 0, 0, 0, 0);
    run_access("lhu", 0, 3'b101, 32'h8000_0006, 0, 1,
               32'h8000_0004, 0, 0, 32'h8001_0000, 0, 0, 0, 0, 32'h0000_8001);
    run_access("lw", 0, 3'b010, 32'h8000_0008, 0, 1,
               32'h8000_0008, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 32'h1234_5678);
    run_access("ld32", 0, 3'b011, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_access("lwu32", 0, 3'b110, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_access("op111", 0, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_access("sbu", 1, 3'b100, 32'h8000_0000, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
    run_access("lw_split", 0, 3'b010, 32'h8000_0003, 0, 2,
               32'h8000_0000, 0, 0, 32'hAA00_0000,
               32'h8000_0004, 0, 0, 32'h0033_2211, 32'h3322_11AA);
    run_access("sw_split", 1, 3'b010, 32'h8000_0002, 32'h1122_3344, 2,
               32'h8000_0000, 32'h3344_0000, 4'b1100, 0,
               32'h8000_0004, 32'h0000_1122, 4'b0011, 0, 0);
    run_access("lh_inword", 0, 3'b001, 32'h8000_0001, 0, 1,
               32'h8000_0000, 0, 0, 32'h00F0_E000, 0, 0, 0, 0, 32'hFFFF_F0E0);
`else
    run_access("lw_mis", 0, 3'b010, 32'h8000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_access("sw_mis", 1, 3'b010, 32'h8000_0002, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_access("lh_mis", 0, 3'b001, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // stray bus response while idle must not produce a completion
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    check("stray.resp_valid", resp_valid, 0);
    check("stray.req_ready", req_ready, 1);

    // bus stall in REQ0, then reset while waiting for the response
    mem_req_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_op = 3'b010;
    req_addr = 32'h8000_0010; req_wdata = 32'hCAFE_F00D;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall.mreqv", mem_req_valid, 1);
      check("stall.bus", {mem_we, mem_addr, mem_wdata, mem_wmask},
            {1'b1, 32'h8000_0010, 32'hCAFE_F00D, 4'b1111});
      step();
    end
    mem_req_ready = 1'b1;
    step();
    check("stall.wait0", {mem_req_valid, req_ready, mem_we}, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.req_ready", req_ready, 1);
    check("midrst.resp", {resp_valid, resp_fault, resp_rdata}, 0);
    check("midrst.bus", {mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask}, 0);
    step();
    rst = 1'b0;
    step();
    run_access("post_rst_lw", 0, 3'b010, 32'h8000_0020, 0, 1,
               32'h8000_0020, 0, 0, 32'h0BAD_CAFE, 0, 0, 0, 0, 32'h0BAD_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
